// File: rtl/merged_pe_array.sv
// merged_pe_array
// Pipelined array of P merged f/g processing elements for the polar SC
// decoder datapath. Each lane takes two W-bit two's-complement LLRs and
// produces the min-sum f result, both saturated g candidates (b+a, b-a),
// the g picked by the lane's partial-sum bit, and a saturation flag.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input beat handshake (in_ready combinational from out_ready)
//   llr_a, llr_b         lane i operand at [i*W +: W]
//   u_sel                lane i partial-sum bit (0 -> g0, 1 -> g1)
//   out_valid / out_ready output beat handshake
//   f_out, g0_out, g1_out, g_out  lane i results, same packing as inputs
//   sat_flag             lane i: g0 or g1 clamped in this beat
//   sat_count, sat_clr   saturating count of accepted beats with any sat_flag, clear
module merged_pe_array #(
  parameter int W  = 9,
  parameter int P  = 4,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [P*W-1:0] llr_a,
  input  logic [P*W-1:0] llr_b,
  input  logic [P-1:0]   u_sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P*W-1:0] f_out,
  output logic [P*W-1:0] g0_out,
  output logic [P*W-1:0] g1_out,
  output logic [P*W-1:0] g_out,
  output logic [P-1:0]   sat_flag,
  output logic [CW-1:0]  sat_count,
  input  logic           sat_clr
);

  localparam int M = W - 1;
  localparam logic [M-1:0] MAG_MAX = '1;
  localparam logic [W-1:0] NEG_LIM = {1'b1, {M{1'b0}}};

  // Sign-magnitude y + x. Result is {sign, W-bit magnitude}; the extra
  // magnitude bit holds the overflow that stage 2 clamps.
  function automatic logic [W:0] sm_add(input logic sx, input logic [M-1:0] mx,
                                        input logic sy, input logic [M-1:0] my);
    logic [W:0] r;
    r = '0;
    if (sx == sy) begin
      r[W]     = sy;
      r[W-1:0] = {1'b0, mx} + {1'b0, my};
    end else if (my > mx) begin
      r[W]     = sy;
      r[W-1:0] = {1'b0, my - mx};
    end else if (mx > my) begin
      r[W]     = sx;
      r[W-1:0] = {1'b0, mx - my};
    end
    // equal magnitudes with unlike signs: positive zero (r stays 0)
    return r;
  endfunction

  function automatic logic [W-1:0] to_tc(input logic s, input logic [M-1:0] m);
    logic [W-1:0] t;
    t = {1'b0, m};
    return s ? (W'(0) - t) : t;
  endfunction

  logic           v1, v2, adv1, adv2;
  logic [P-1:0]   fs1, g0s1, g1s1, u1;
  logic [P*M-1:0] fm1;
  logic [P*W-1:0] g0m1, g1m1;

  logic [P-1:0]   fs_d, g0s_d, g1s_d, sat_d;
  logic [P*M-1:0] fm_d;
  logic [P*W-1:0] g0m_d, g1m_d, f_d, g0_d, g1_d, g_d;

  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  for (genvar i = 0; i < P; i++) begin : g_lane
    logic [W-1:0] a, b;
    logic         sa, sb;
    logic [M-1:0] ma, mb;
    logic [W:0]   g0_sm, g1_sm;
    logic         g0_ov, g1_ov;
    logic [M-1:0] g0_m, g1_m;
    logic [W-1:0] g0_tc, g1_tc;

    // stage 1: clamp the most negative code, convert to sign-magnitude
    assign a  = llr_a[i*W +: W];
    assign b  = llr_b[i*W +: W];
    assign sa = a[W-1];
    assign sb = b[W-1];
    assign ma = (a == NEG_LIM) ? MAG_MAX : (sa ? (M'(0) - a[M-1:0]) : a[M-1:0]);
    assign mb = (b == NEG_LIM) ? MAG_MAX : (sb ? (M'(0) - b[M-1:0]) : b[M-1:0]);

    assign g0_sm = sm_add(sa, ma, sb, mb);
    assign g1_sm = sm_add(~sa, ma, sb, mb);

    assign fs_d[i]           = sa ^ sb;
    assign fm_d[i*M +: M]    = (ma <= mb) ? ma : mb;
    assign g0s_d[i]          = g0_sm[W];
    assign g1s_d[i]          = g1_sm[W];
    assign g0m_d[i*W +: W]   = g0_sm[W-1:0];
    assign g1m_d[i*W +: W]   = g1_sm[W-1:0];

    // stage 2: clamp magnitudes, re-encode, select
    assign g0_ov = g0m1[i*W +: W] > {1'b0, MAG_MAX};
    assign g1_ov = g1m1[i*W +: W] > {1'b0, MAG_MAX};
    assign g0_m  = g0_ov ? MAG_MAX : g0m1[i*W +: M];
    assign g1_m  = g1_ov ? MAG_MAX : g1m1[i*W +: M];
    assign g0_tc = to_tc(g0s1[i], g0_m);
    assign g1_tc = to_tc(g1s1[i], g1_m);

    assign f_d[i*W +: W]  = to_tc(fs1[i], fm1[i*M +: M]);
    assign g0_d[i*W +: W] = g0_tc;
    assign g1_d[i*W +: W] = g1_tc;
    assign g_d[i*W +: W]  = u1[i] ? g1_tc : g0_tc;
    assign sat_d[i]       = g0_ov | g1_ov;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      fs1      <= '0;
      fm1      <= '0;
      g0s1     <= '0;
      g1s1     <= '0;
      g0m1     <= '0;
      g1m1     <= '0;
      u1       <= '0;
      f_out    <= '0;
      g0_out   <= '0;
      g1_out   <= '0;
      g_out    <= '0;
      sat_flag <= '0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          fs1  <= fs_d;
          fm1  <= fm_d;
          g0s1 <= g0s_d;
          g1s1 <= g1s_d;
          g0m1 <= g0m_d;
          g1m1 <= g1m_d;
          u1   <= u_sel;
        end
      end
      if (adv2) begin
        v2 <= v1;
        // only real beats overwrite the outputs, so data holds across bubbles
        if (v1) begin
          f_out    <= f_d;
          g0_out   <= g0_d;
          g1_out   <= g1_d;
          g_out    <= g_d;
          sat_flag <= sat_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_count <= '0;
    end else if (v2 && out_ready && (|sat_flag) && (sat_count != '1)) begin
      sat_count <= sat_count + CW'(1);
    end
  end

endmodule
